// File: rtl/vga_pkg.sv
// Shared VGA timing constants, FSM/direction encodings and sprite colour sequence.
package vga_pkg;

   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned V_TICK_LINE = 481;

   typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;
   typedef enum logic {DirPos = 1'b0, DirNeg = 1'b1} dir_e;

   localparam logic [2:0] ColorInit = 3'b100;
   localparam logic [2:0] Color1    = 3'b010;
   localparam logic [2:0] Color2    = 3'b001;
   localparam logic [2:0] Color3    = 3'b110;
   localparam logic [2:0] Color4    = 3'b011;
   localparam logic [2:0] Color5    = 3'b101;
   localparam logic [2:0] Color6    = 3'b111;

   typedef struct packed {
      logic [10:0] pos;
      dir_e        dir;
      logic        hit;
   } axis_t;

   function automatic logic [2:0] next_color(input logic [2:0] c);
      logic [2:0] n;
      n = ColorInit;
      case (c)
         ColorInit: n = Color1;
         Color1:    n = Color2;
         Color2:    n = Color3;
         Color3:    n = Color4;
         Color4:    n = Color5;
         Color5:    n = Color6;
         default:   n = ColorInit;
      endcase
      return n;
   endfunction

   // One axis of the update: auto bounces off the limits, manual clamps to them.
   function automatic axis_t axis_next(input logic [9:0] pos, input dir_e dir, input logic inc,
                                       input logic dec, input logic auto_mode,
                                       input logic signed [10:0] step,
                                       input logic signed [10:0] max);
      axis_t             r;
      logic signed [10:0] p;
      logic signed [10:0] n;
      p     = $signed({1'b0, pos});
      n     = p;
      r.dir = dir;
      r.hit = 1'b0;
      if (auto_mode) begin
         if (dir == DirPos) begin
            n = p + step;
            if (n >= max) begin
               n     = max;
               r.dir = DirNeg;
               r.hit = 1'b1;
            end
         end else begin
            n = p - step;
            if (n <= 11'sd0) begin
               n     = 11'sd0;
               r.dir = DirPos;
               r.hit = 1'b1;
            end
         end
      end else begin
         if (inc && !dec) begin
            n = p + step;
         end else if (dec && !inc) begin
            n = p - step;
         end
         if (n > max) begin
            n     = max;
            r.hit = 1'b1;
         end else if (n < 11'sd0) begin
            n     = 11'sd0;
            r.hit = 1'b1;
         end
      end
      r.pos = n;
      return r;
   endfunction

endpackage

// File: rtl/push_debounce.sv
// Per-bit 2-FF synchroniser plus stability counter; a level is accepted only after
// DB_CYCLES consecutive clocks of the new synchronised value.
module push_debounce #(
   parameter int unsigned DB_CYCLES = 500000,
   parameter int unsigned WIDTH     = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] db_o
);

   localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic            db_q;
      logic [CntW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
         end else if (sync2_q[i] == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
            db_q  <= sync2_q[i];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign db_o[i] = db_q;
   end

endmodule

// File: rtl/object_motion_ctrl.sv
// Per-frame sprite position/colour sequencer: detects the update line, then runs
// IDLE -> CALC -> COMMIT once, in manual (buttons) or auto (bounce) mode.
module object_motion_ctrl #(
   parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int unsigned OBJ_SIZE    = 8,
   parameter int unsigned STEP        = 1,
   parameter int unsigned V_TICK_LINE = vga_pkg::V_TICK_LINE,
   parameter int unsigned DB_CYCLES   = 500000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] push_i,
   input  logic [2:0] switch_i,
   input  logic [9:0] pixel_y_i,
   output logic [9:0] obj_x_o,
   output logic [9:0] obj_y_o,
   output logic [2:0] obj_color_o,
   output logic       frame_tick_o,
   output logic       edge_hit_o
);
   import vga_pkg::*;

   localparam logic signed [10:0] XMax = 11'(H_ACTIVE - OBJ_SIZE);
   localparam logic signed [10:0] YMax = 11'(V_ACTIVE - OBJ_SIZE);
   localparam logic [9:0] XInit = 10'((H_ACTIVE - OBJ_SIZE) / 2);
   localparam logic [9:0] YInit = 10'((V_ACTIVE - OBJ_SIZE) / 2);
   localparam logic [9:0] TickLine = 10'(V_TICK_LINE);

   logic [3:0]         push_db;
   logic               tick;
   logic signed [10:0] step;
   logic               auto_mode;
   axis_t              ax_d, ay_d, ax_q, ay_q;

   state_e     state_q;
   logic [9:0] prev_y_q, obj_x_q, obj_y_q;
   logic [2:0] color_q;
   dir_e       dir_x_q, dir_y_q;
   logic       frame_tick_q, edge_hit_q, auto_q;

   push_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .WIDTH    (4)
   ) u_push_debounce (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw_i (push_i),
      .db_o  (push_db)
   );

   assign tick      = (pixel_y_i == TickLine) && (prev_y_q != TickLine);
   assign auto_mode = switch_i[0];

   always_comb begin
      step = 11'(STEP * (32'(switch_i[2:1]) + 32'd1));
      ax_d = axis_next(obj_x_q, dir_x_q, push_db[0], push_db[1], auto_mode, step, XMax);
      ay_d = axis_next(obj_y_q, dir_y_q, push_db[2], push_db[3], auto_mode, step, YMax);
   end

   // prev_y resets to the tick line so a reset released mid-line cannot fire a tick.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         prev_y_q     <= TickLine;
         obj_x_q      <= XInit;
         obj_y_q      <= YInit;
         color_q      <= ColorInit;
         dir_x_q      <= DirPos;
         dir_y_q      <= DirPos;
         frame_tick_q <= 1'b0;
         edge_hit_q   <= 1'b0;
         auto_q       <= 1'b0;
         ax_q         <= '0;
         ay_q         <= '0;
      end else begin
         prev_y_q     <= pixel_y_i;
         frame_tick_q <= tick;
         edge_hit_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tick) state_q <= StCalc;
            end
            StCalc: begin
               ax_q    <= ax_d;
               ay_q    <= ay_d;
               auto_q  <= auto_mode;
               state_q <= StCommit;
            end
            StCommit: begin
               obj_x_q    <= ax_q.pos[9:0];
               obj_y_q    <= ay_q.pos[9:0];
               dir_x_q    <= ax_q.dir;
               dir_y_q    <= ay_q.dir;
               edge_hit_q <= ax_q.hit | ay_q.hit;
               if (auto_q && (ax_q.hit || ay_q.hit)) color_q <= next_color(color_q);
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign obj_x_o      = obj_x_q;
   assign obj_y_o      = obj_y_q;
   assign obj_color_o  = color_q;
   assign frame_tick_o = frame_tick_q;
   assign edge_hit_o   = edge_hit_q;

endmodule

// File: tb/tb_object_motion_ctrl.sv
// Directed bench for object_motion_ctrl with a short debounce window.
module tb_object_motion_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] push;
   logic [2:0] sw;
   logic [9:0] pixel_y;
   logic [9:0] obj_x, obj_y;
   logic [2:0] obj_color;
   logic       frame_tick, edge_hit;

   int n_tests = 0;
   int n_fail  = 0;

   int         f_tick, f_edge;
   logic [9:0] f_x, f_y;
   logic [2:0] f_c;

   object_motion_ctrl #(
      .DB_CYCLES(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .push_i      (push),
      .switch_i    (sw),
      .pixel_y_i   (pixel_y),
      .obj_x_o     (obj_x),
      .obj_y_o     (obj_y),
      .obj_color_o (obj_color),
      .frame_tick_o(frame_tick),
      .edge_hit_o  (edge_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive 480 -> 481 (held for 'hold' clocks) -> 482; count pulses and capture
   // the outputs two clocks after the observed tick.
   task automatic run_frame(input int hold, output int n_tick, output int n_edge,
                            output logic [9:0] x2, output logic [9:0] y2,
                            output logic [2:0] c2);
      int tick_at;
      n_tick  = 0;
      n_edge  = 0;
      tick_at = -10;
      x2      = '0;
      y2      = '0;
      c2      = '0;
      @(negedge clk);
      pixel_y = 10'd480;
      @(negedge clk);
      pixel_y = 10'd481;
      for (int i = 0; i < hold + 6; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            n_tick++;
            tick_at = i;
         end
         if (edge_hit) n_edge++;
         if (i == tick_at + 2) begin
            x2 = obj_x;
            y2 = obj_y;
            c2 = obj_color;
         end
         if (i == hold - 1) pixel_y = 10'd482;
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      push    = 4'b0000;
      sw      = 3'b000;
      pixel_y = 10'd0;
      wait_clks(3);
      check_eq("rst_obj_x", 32'(obj_x), 32'd316);
      check_eq("rst_obj_y", 32'(obj_y), 32'd236);
      check_eq("rst_color", 32'(obj_color), 32'b100);
      check_eq("rst_tick", 32'(frame_tick), 32'd0);
      check_eq("rst_edge", 32'(edge_hit), 32'd0);
      rst_n = 1'b1;
      wait_clks(3);
      check_eq("idle_tick", 32'(frame_tick), 32'd0);

      // Idle frame, no buttons
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("idle_frame_ticks", 32'(f_tick), 32'd1);
      check_eq("idle_frame_edge", 32'(f_edge), 32'd0);
      check_eq("idle_frame_x", 32'(f_x), 32'd316);
      check_eq("idle_frame_y", 32'(f_y), 32'd236);

      // 3-clock glitch on down must not register; long hold on 481 ticks once
      push = 4'b0100;
      wait_clks(3);
      push = 4'b0000;
      wait_clks(8);
      run_frame(100, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("hold481_ticks", 32'(f_tick), 32'd1);
      check_eq("glitch_y", 32'(f_y), 32'd236);
      check_eq("glitch_y_end", 32'(obj_y), 32'd236);

      // Manual right, step 1
      push = 4'b0001;
      wait_clks(8);
      for (int k = 1; k <= 3; k++) begin
         run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
         check_eq("man_right_x", 32'(f_x), 32'(316 + k));
      end
      check_eq("man_right_y", 32'(obj_y), 32'd236);

      // Opposing buttons cancel
      push = 4'b0011;
      wait_clks(8);
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("opposed_x", 32'(f_x), 32'd319);
      check_eq("opposed_edge", 32'(f_edge), 32'd0);

      // Step 3 once, then step 4 up to 630
      push = 4'b0001;
      sw   = 3'b100;
      wait_clks(8);
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("step3_x", 32'(f_x), 32'd322);
      sw = 3'b110;
      for (int k = 0; k < 77; k++) run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("step4_x", 32'(obj_x), 32'd630);

      // Clamp at XMAX
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("clamp_x", 32'(f_x), 32'd632);
      check_eq("clamp_edge", 32'(f_edge), 32'd1);
      check_eq("clamp_color", 32'(f_c), 32'b100);

      // Left, step 1 -> 631
      push = 4'b0010;
      sw   = 3'b000;
      wait_clks(8);
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("left_x", 32'(f_x), 32'd631);
      push = 4'b0000;
      wait_clks(8);

      // Auto bounce at right edge
      sw = 3'b001;
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("auto_hit_x", 32'(f_x), 32'd632);
      check_eq("auto_hit_y", 32'(f_y), 32'd237);
      check_eq("auto_hit_color", 32'(f_c), 32'b010);
      check_eq("auto_hit_edge", 32'(f_edge), 32'd1);
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("auto_back_x", 32'(f_x), 32'd631);
      check_eq("auto_back_y", 32'(f_y), 32'd238);
      check_eq("auto_back_color", 32'(f_c), 32'b010);
      check_eq("auto_back_edge", 32'(f_edge), 32'd0);

      // Reset while in CALC
      @(negedge clk);
      pixel_y = 10'd480;
      @(negedge clk);
      pixel_y = 10'd481;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_x", 32'(obj_x), 32'd316);
      check_eq("midrst_y", 32'(obj_y), 32'd236);
      check_eq("midrst_color", 32'(obj_color), 32'b100);
      check_eq("midrst_tick", 32'(frame_tick), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      f_tick = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (frame_tick) f_tick++;
      end
      check_eq("postrst_no_tick", 32'(f_tick), 32'd0);
      check_eq("postrst_x", 32'(obj_x), 32'd316);
      pixel_y = 10'd482;
      run_frame(2, f_tick, f_edge, f_x, f_y, f_c);
      check_eq("postrst_frame_ticks", 32'(f_tick), 32'd1);
      check_eq("postrst_frame_x", 32'(f_x), 32'd317);
      check_eq("postrst_frame_y", 32'(f_y), 32'd237);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
